// File: rtl/mem_map_pkg.sv
// Address map, status bit layout and region decode shared by the
// data memory controller and its output FIFO.
package mem_map_pkg;

    localparam logic [31:0] ADDR_CYCLE     = 32'h0001_0000;
    localparam logic [31:0] ADDR_FIFO_DATA = 32'h0001_0004;
    localparam logic [31:0] ADDR_FIFO_STAT = 32'h0001_0008;
    localparam logic [31:0] ADDR_STAT_CLR  = 32'h0001_000C;

    localparam int STAT_CNT_W = 4;
    localparam int STAT_FULL  = 4;
    localparam int STAT_EMPTY = 5;
    localparam int STAT_OVF   = 6;

    typedef enum logic [2:0] {
        RGN_RAM,
        RGN_CYCLE,
        RGN_FIFO_DATA,
        RGN_FIFO_STAT,
        RGN_STAT_CLR,
        RGN_NONE
    } region_t;

    // Takes the word address only; byte offset never reaches decode.
    function automatic region_t decode(input logic [29:0] waddr);
        if (waddr[29:10] == 20'h0)                return RGN_RAM;
        else if (waddr == ADDR_CYCLE[31:2])       return RGN_CYCLE;
        else if (waddr == ADDR_FIFO_DATA[31:2])   return RGN_FIFO_DATA;
        else if (waddr == ADDR_FIFO_STAT[31:2])   return RGN_FIFO_STAT;
        else if (waddr == ADDR_STAT_CLR[31:2])    return RGN_STAT_CLR;
        else                                      return RGN_NONE;
    endfunction

endpackage

// File: rtl/out_fifo.sv
// Synchronous word FIFO with registered head; push while full is only
// accepted when a pop frees the head slot in the same cycle.
module out_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [W-1:0]  data
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign data    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    // Pointer arithmetic wraps naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(do_push);
            rd_ptr <= rd_ptr + PW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Processor data memory: word RAM, free-running cycle counter and an
// output FIFO behind a small memory-mapped register block.
module data_mem_ctrl
    import mem_map_pkg::*;
#(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memw_m,
    input  logic [31:0] m_address,
    input  logic [31:0] m_data,
    output logic [31:0] input_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram [RAM_WORDS];
    logic [31:0]   cycle_cnt;
    logic          overflow;
    region_t       region;
    logic [AW-1:0] idx;
    logic          wr;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [31:0]   fifo_stat;
    logic [31:0]   rd_next;
    logic          unused_lsb;

    assign unused_lsb = &{1'b0, m_address[1:0]};
    assign region     = decode(m_address[31:2]);
    assign idx        = m_address[AW+1:2];
    assign wr         = memw_m & ~rst;
    assign push       = wr && (region == RGN_FIFO_DATA);
    assign pop        = out_valid & out_ready;
    assign out_valid  = ~empty;

    always_ff @(posedge clk) begin
        if (wr && region == RGN_RAM)
            ram[idx] <= m_data;
    end

    out_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (m_data),
        .full  (full),
        .empty (empty),
        .count (count),
        .data  (out_data)
    );

    always_comb begin
        fifo_stat                   = '0;
        fifo_stat[STAT_CNT_W-1:0]   = STAT_CNT_W'(count);
        fifo_stat[STAT_FULL]        = full;
        fifo_stat[STAT_EMPTY]       = empty;
        fifo_stat[STAT_OVF]         = overflow;
    end

    // Write-first: a same-cycle RAM write is forwarded to the read port.
    always_comb begin
        rd_next = '0;
        case (region)
            RGN_RAM:       rd_next = memw_m ? m_data : ram[idx];
            RGN_CYCLE:     rd_next = cycle_cnt;
            RGN_FIFO_STAT: rd_next = fifo_stat;
            default:       rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            input_data <= '0;
            cycle_cnt  <= '0;
            overflow   <= 1'b0;
        end else begin
            input_data <= rd_next;
            cycle_cnt  <= cycle_cnt + 32'd1;
            if (push && full && !pop)
                overflow <= 1'b1;
            else if (wr && region == RGN_STAT_CLR)
                overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed checks of RAM, cycle counter, output FIFO and reset behaviour
// of data_mem_ctrl; inputs change on falling edges, outputs read there too.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        memw_m;
    logic [31:0] m_address;
    logic [31:0] m_data;
    logic [31:0] input_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] A_CYC  = 32'h0001_0000;
    localparam logic [31:0] A_FD   = 32'h0001_0004;
    localparam logic [31:0] A_FS   = 32'h0001_0008;
    localparam logic [31:0] A_CLR  = 32'h0001_000C;

    data_mem_ctrl #(.RAM_WORDS(1024), .FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .memw_m     (memw_m),
        .m_address  (m_address),
        .m_data     (m_data),
        .input_data (input_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at a falling edge, return at the next one.
    task automatic cyc(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
        memw_m    = we;
        m_address = a;
        m_data    = d;
        out_ready = rdy;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        memw_m = 1'b0;
        m_address = '0;
        m_data = '0;
        out_ready = 1'b0;
        @(negedge clk);
        cyc(1'b0, A_CYC, 32'h0, 1'b1);
        chk("rst_input_data", input_data, 32'h0);
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);

        // Cycle counter: first edge out of reset samples 0.
        rst = 1'b0;
        for (int i = 0; i < 10; i++)
            cyc(1'b0, A_CYC, 32'h0, 1'b0);
        cyc(1'b0, A_CYC, 32'h0, 1'b0);
        chk("cycle_10", input_data, 32'd10);

        force dut.cycle_cnt = 32'hFFFF_FFFF;
        cyc(1'b0, A_CYC, 32'h0, 1'b0);
        release dut.cycle_cnt;
        cyc(1'b0, A_CYC, 32'h0, 1'b0);
        chk("cycle_max", input_data, 32'hFFFF_FFFF);
        cyc(1'b0, A_CYC, 32'h0, 1'b0);
        chk("cycle_wrap", input_data, 32'h0);
        cyc(1'b0, A_CYC, 32'h0, 1'b0);
        chk("cycle_after_wrap", input_data, 32'h1);

        // RAM write then read, byte offset ignored.
        cyc(1'b1, 32'h10, 32'h0000_0190, 1'b0);
        cyc(1'b0, 32'h10, 32'h0, 1'b0);
        chk("ram_rd_10", input_data, 32'h0000_0190);
        cyc(1'b0, 32'h13, 32'h0, 1'b0);
        chk("ram_rd_13", input_data, 32'h0000_0190);

        cyc(1'b1, 32'h20, 32'hDEAD_BEEF, 1'b0);
        chk("write_first", input_data, 32'hDEAD_BEEF);
        cyc(1'b0, 32'h20, 32'h0, 1'b0);
        chk("ram_rd_20", input_data, 32'hDEAD_BEEF);

        // Unmapped write must not alias RAM; unmapped/WO reads give 0.
        cyc(1'b1, 32'h0, 32'h0000_1111, 1'b0);
        cyc(1'b1, 32'h1000, 32'h0000_2222, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 1'b0);
        chk("no_alias", input_data, 32'h0000_1111);
        cyc(1'b0, 32'h0002_0000, 32'h0, 1'b0);
        chk("unmapped_rd", input_data, 32'h0);
        cyc(1'b0, A_FD, 32'h0, 1'b0);
        chk("fifo_data_rd", input_data, 32'h0);
        cyc(1'b0, A_FS, 32'h0, 1'b0);
        chk("stat_empty", input_data, 32'h20);

        // Overflow: nine pushes into an eight-deep FIFO.
        chk("valid_before_push", {31'h0, out_valid}, 32'h0);
        for (int i = 1; i <= 9; i++)
            cyc(1'b1, A_FD, 32'(i), 1'b0);
        cyc(1'b0, A_FS, 32'h0, 1'b0);
        chk("stat_full_ovf", input_data, 32'h58);
        chk("head_1", out_data, 32'h1);
        cyc(1'b0, A_FS, 32'h0, 1'b0);
        chk("head_stable", out_data, 32'h1);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_valid", {31'h0, out_valid}, 32'h1);
            chk("drain_data", out_data, 32'(i));
            cyc(1'b0, 32'h0, 32'h0, 1'b1);
        end
        chk("drained_valid", {31'h0, out_valid}, 32'h0);
        cyc(1'b0, A_FS, 32'h0, 1'b0);
        chk("stat_ovf_sticky", input_data, 32'h60);
        cyc(1'b1, A_CLR, 32'h0, 1'b0);
        cyc(1'b0, A_FS, 32'h0, 1'b0);
        chk("stat_cleared", input_data, 32'h20);

        // Full FIFO with simultaneous push and pop.
        for (int i = 1; i <= 8; i++)
            cyc(1'b1, A_FD, 32'h10 + 32'(i), 1'b0);
        chk("first_push_valid", {31'h0, out_valid}, 32'h1);
        cyc(1'b1, A_FD, 32'hA, 1'b1);
        cyc(1'b0, A_FS, 32'h0, 1'b0);
        chk("stat_push_pop", input_data, 32'h18);
        for (int i = 2; i <= 8; i++) begin
            chk("pp_drain", out_data, 32'h10 + 32'(i));
            cyc(1'b0, 32'h0, 32'h0, 1'b1);
        end
        chk("pp_last", out_data, 32'hA);
        cyc(1'b0, 32'h0, 32'h0, 1'b1);
        chk("pp_empty", {31'h0, out_valid}, 32'h0);

        // Reset with traffic queued; writes during reset ignored.
        for (int i = 0; i < 3; i++)
            cyc(1'b1, A_FD, 32'h30 + 32'(i), 1'b0);
        rst = 1'b1;
        cyc(1'b1, 32'h10, 32'h0000_0BAD, 1'b1);
        chk("mid_rst_valid", {31'h0, out_valid}, 32'h0);
        chk("mid_rst_data", out_data, 32'h0);
        chk("mid_rst_rd", input_data, 32'h0);
        rst = 1'b0;
        cyc(1'b0, A_FS, 32'h0, 1'b0);
        chk("post_rst_stat", input_data, 32'h20);
        cyc(1'b0, 32'h10, 32'h0, 1'b0);
        chk("ram_survives_rst", input_data, 32'h0000_0190);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
